// File: rtl/fwd_hazard_ctrl_if.sv
// Bundle between the decode stage and the forwarding / hazard unit.
interface fwd_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) ();

  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] id_dest;
  logic              id_regwrite;
  logic              id_memread;
  logic              hold;
  logic              flush;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              stall;
  logic              bubble;
  logic [CNT_W-1:0]  stall_cnt;

  // Pipeline side: presents the ID instruction and consumes the controls.
  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest,
    output id_regwrite, id_memread, hold, flush,
    input  fwd_a_sel, fwd_b_sel, stall, bubble, stall_cnt
  );

  // Control unit side.
  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest,
    input  id_regwrite, id_memread, hold, flush,
    output fwd_a_sel, fwd_b_sel, stall, bubble, stall_cnt
  );

endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard unit for a classic 5-stage pipeline.
// Tracks shadow copies of the EX and MEM producers and emits registered
// operand selects aligned with the instruction currently in EX.
// Select encoding: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result.
module fwd_hazard_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input logic              clk,
  input logic              rst,
  fwd_hazard_ctrl_if.slave bus
);

  localparam logic [1:0] SelRf  = 2'b00;
  localparam logic [1:0] SelMem = 2'b01;  // EX/MEM pipeline register
  localparam logic [1:0] SelWb  = 2'b10;  // MEM/WB pipeline register

  // Shadow of the instruction in EX. memread is only needed here: a load is
  // only a hazard while it sits in EX.
  logic              ex_valid_q, ex_valid_d;
  logic [REG_AW-1:0] ex_dest_q, ex_dest_d;
  logic              ex_regwrite_q, ex_regwrite_d;
  logic              ex_memread_q, ex_memread_d;

  // Shadow of the instruction in MEM. The WB stage is never a forward source
  // (register file is write-first), so no copy of it is kept.
  logic              mem_valid_q;
  logic [REG_AW-1:0] mem_dest_q;
  logic              mem_regwrite_q;

  logic [1:0]        sel_a_q, sel_a_d;
  logic [1:0]        sel_b_q, sel_b_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic ex_fwd, mem_fwd, hazard, stall, bubble;

  // Hazard detection, stall/bubble generation and next-state for EX and selects.
  always_comb begin
    ex_fwd  = ex_valid_q & ex_regwrite_q & (ex_dest_q != '0);
    mem_fwd = mem_valid_q & mem_regwrite_q & (mem_dest_q != '0);

    hazard = bus.id_valid & ex_fwd & ex_memread_q &
             ((bus.id_use_rs & (bus.id_rs == ex_dest_q)) |
              (bus.id_use_rt & (bus.id_rt == ex_dest_q)));

    // Flush squashes the ID instruction, so holding the front end is pointless.
    stall  = hazard & ~bus.flush & ~rst;
    bubble = (hazard | bus.flush) & ~rst;

    ex_valid_d    = bus.id_valid & ~bubble;
    ex_dest_d     = bus.id_dest;
    ex_regwrite_d = bus.id_regwrite;
    ex_memread_d  = bus.id_memread;

    // Newest producer (EX) wins over the older one (MEM).
    sel_a_d = SelRf;
    if (bus.id_use_rs) begin
      if (ex_fwd && (bus.id_rs == ex_dest_q)) begin
        sel_a_d = SelMem;
      end else if (mem_fwd && (bus.id_rs == mem_dest_q)) begin
        sel_a_d = SelWb;
      end
    end

    sel_b_d = SelRf;
    if (bus.id_use_rt) begin
      if (ex_fwd && (bus.id_rt == ex_dest_q)) begin
        sel_b_d = SelMem;
      end else if (mem_fwd && (bus.id_rt == mem_dest_q)) begin
        sel_b_d = SelWb;
      end
    end

    if (bubble) begin
      sel_a_d = SelRf;
      sel_b_d = SelRf;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Advance the shadow pipeline and selects unless the pipeline is frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;
      ex_dest_q      <= '0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      mem_valid_q    <= 1'b0;
      mem_dest_q     <= '0;
      mem_regwrite_q <= 1'b0;
      sel_a_q        <= SelRf;
      sel_b_q        <= SelRf;
      stall_cnt_q    <= '0;
    end else if (!bus.hold) begin
      ex_valid_q     <= ex_valid_d;
      ex_dest_q      <= ex_dest_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_memread_q   <= ex_memread_d;
      mem_valid_q    <= ex_valid_q;
      mem_dest_q     <= ex_dest_q;
      mem_regwrite_q <= ex_regwrite_q;
      sel_a_q        <= sel_a_d;
      sel_b_q        <= sel_b_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  // Drive the interface outputs.
  always_comb begin
    bus.fwd_a_sel = sel_a_q;
    bus.fwd_b_sel = sel_b_q;
    bus.stall     = stall;
    bus.bubble    = bubble;
    bus.stall_cnt = stall_cnt_q;
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: a table of per-cycle ID instructions with
// hand-computed controls, then hand-written hold and reset-mid-stall sequences.
module tb_fwd_hazard_ctrl;

  logic clk;
  logic rst;

  fwd_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) bus ();

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dest;
    logic       rw;
    logic       mr;
    logic       flush;
    logic       e_stall;
    logic       e_bubble;
    logic [1:0] e_a;
    logic [1:0] e_b;
    int         e_cnt;
  } vec_t;

  int n_pass;
  int n_total;

  function automatic vec_t mk(input logic v, input int rs, input int rt, input logic urs,
                              input logic urt, input int dest, input logic rw,
                              input logic mr, input logic flush, input logic es,
                              input logic eb, input int ea, input int ebs, input int ecnt);
    vec_t t;
    t.v = v;       t.rs = 5'(rs);   t.rt = 5'(rt);     t.urs = urs;   t.urt = urt;
    t.dest = 5'(dest); t.rw = rw;   t.mr = mr;         t.flush = flush;
    t.e_stall = es; t.e_bubble = eb; t.e_a = 2'(ea);   t.e_b = 2'(ebs);
    t.e_cnt = ecnt;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input vec_t t, input logic hold);
    bus.id_valid    = t.v;
    bus.id_rs       = t.rs;
    bus.id_rt       = t.rt;
    bus.id_use_rs   = t.urs;
    bus.id_use_rt   = t.urt;
    bus.id_dest     = t.dest;
    bus.id_regwrite = t.rw;
    bus.id_memread  = t.mr;
    bus.flush       = t.flush;
    bus.hold        = hold;
  endtask

  // One cycle: drive at negedge, check combinational controls, clock, check state.
  task automatic apply(input vec_t t, input logic hold, input string tag);
    @(negedge clk);
    drive(t, hold);
    #1;
    chk({tag, " stall"}, int'(bus.stall), int'(t.e_stall));
    chk({tag, " bubble"}, int'(bus.bubble), int'(t.e_bubble));
    @(posedge clk);
    #1;
    chk({tag, " sel_a"}, int'(bus.fwd_a_sel), int'(t.e_a));
    chk({tag, " sel_b"}, int'(bus.fwd_b_sel), int'(t.e_b));
    chk({tag, " stall_cnt"}, int'(bus.stall_cnt), t.e_cnt);
  endtask

  vec_t tbl[16];
  vec_t h;

  initial begin
    n_pass  = 0;
    n_total = 0;

    // v rs rt urs urt dest rw mr flush | stall bubble a b cnt
    tbl[0]  = mk(1,  1,  2, 1, 1,  3, 1, 0, 0, 0, 0, 0, 0, 0); // r3<-r1+r2
    tbl[1]  = mk(1,  3,  5, 1, 1,  4, 1, 0, 0, 0, 0, 1, 0, 0); // r4<-r3+r5 back-to-back
    tbl[2]  = mk(1,  7,  3, 1, 1,  6, 1, 0, 0, 0, 0, 0, 2, 0); // r6<-r7+r3 distance 2
    tbl[3]  = mk(1,  1,  1, 1, 1,  3, 1, 0, 0, 0, 0, 0, 0, 0); // r3<-A
    tbl[4]  = mk(1,  2,  2, 1, 1,  3, 1, 0, 0, 0, 0, 0, 0, 0); // r3<-B
    tbl[5]  = mk(1,  3,  3, 1, 1,  9, 1, 0, 0, 0, 0, 1, 1, 0); // use r3: newest wins
    tbl[6]  = mk(1,  1,  0, 1, 0,  8, 1, 1, 0, 0, 0, 0, 0, 0); // lw r8
    tbl[7]  = mk(1,  8,  1, 1, 1,  9, 1, 0, 0, 1, 1, 0, 0, 1); // add r8: load-use stall
    tbl[8]  = mk(1,  8,  1, 1, 1,  9, 1, 0, 0, 0, 0, 2, 0, 1); // retried add gets MEM/WB
    tbl[9]  = mk(1,  2,  0, 1, 0,  0, 1, 1, 0, 0, 0, 0, 0, 1); // lw r0
    tbl[10] = mk(1,  0,  0, 1, 1,  5, 1, 0, 0, 0, 0, 0, 0, 1); // use r0: no stall/fwd
    tbl[11] = mk(1,  1,  0, 1, 0, 12, 1, 1, 0, 0, 0, 0, 0, 1); // lw r12
    tbl[12] = mk(1, 12,  2, 1, 1, 13, 1, 0, 1, 0, 1, 0, 0, 1); // hazard with flush
    tbl[13] = mk(0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1); // squashed slot
    tbl[14] = mk(1,  1,  1, 1, 1, 14, 1, 0, 0, 0, 0, 0, 0, 1); // r14<-r1+r1
    tbl[15] = mk(1, 14, 14, 0, 1, 15, 1, 0, 0, 0, 0, 0, 1, 1); // rs unused: sel_a stays 00

    // Reset with flush asserted: all outputs must be 0.
    rst = 1'b1;
    drive(mk(1, 1, 1, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0), 1'b0);
    #12;
    chk("reset stall", int'(bus.stall), 0);
    chk("reset bubble", int'(bus.bubble), 0);
    chk("reset sel_a", int'(bus.fwd_a_sel), 0);
    chk("reset sel_b", int'(bus.fwd_b_sel), 0);
    chk("reset stall_cnt", int'(bus.stall_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(tbl[13], 1'b0);

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i], 1'b0, $sformatf("vec%0d", i));
    end

    // Hold during a forward and during a load-use stall.
    apply(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 1), 1'b0, "h_prod");
    apply(mk(1, 3, 0, 1, 0, 8, 1, 1, 0, 0, 0, 1, 0, 1), 1'b0, "h_lw");
    h = mk(1, 8, 1, 1, 1, 9, 1, 0, 0, 1, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      apply(h, 1'b1, $sformatf("hold%0d", i));
    end
    apply(mk(1, 8, 1, 1, 1, 9, 1, 0, 0, 1, 1, 0, 0, 2), 1'b0, "h_release");
    apply(mk(1, 8, 1, 1, 1, 9, 1, 0, 0, 0, 0, 2, 0, 2), 1'b0, "h_retry");
    apply(mk(1, 9, 0, 1, 0, 8, 1, 1, 0, 0, 0, 1, 0, 2), 1'b0, "r_lw");

    // Reset asserted in the middle of a load-use stall.
    @(negedge clk);
    drive(mk(1, 8, 8, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    #1;
    chk("pre_rst stall", int'(bus.stall), 1);
    bus.flush = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid_rst stall", int'(bus.stall), 0);
    chk("mid_rst bubble", int'(bus.bubble), 0);
    chk("mid_rst sel_a", int'(bus.fwd_a_sel), 0);
    chk("mid_rst sel_b", int'(bus.fwd_b_sel), 0);
    chk("mid_rst stall_cnt", int'(bus.stall_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    apply(mk(1, 8, 8, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
